// File: rtl/wide_add_sequencer_if.sv
`default_nettype none
// ============================================================================
// wide_add_sequencer_if : request/result bus plus external 16-bit adder bus
// Revision: 1.0
// ============================================================================
interface wide_add_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int WORDS = 4
);
  logic                     start;
  logic [WIDTH*WORDS-1:0]   op_a;
  logic [WIDTH*WORDS-1:0]   op_b;
  logic                     cin;
  logic [WIDTH-1:0]         add_A;
  logic [WIDTH-1:0]         add_B;
  logic                     add_Cin;
  logic [WIDTH-1:0]         add_sum;
  logic                     add_Cout;
  logic [WIDTH*WORDS-1:0]   result;
  logic                     cout;
  logic                     busy;
  logic                     done;

  // master: the sequencer; slave: requester plus the combinational adder
  modport master (
    input  start, op_a, op_b, cin, add_sum, add_Cout,
    output add_A, add_B, add_Cin, result, cout, busy, done
  );
  modport slave (
    output start, op_a, op_b, cin, add_sum, add_Cout,
    input  add_A, add_B, add_Cin, result, cout, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/wide_add_sequencer.sv
`default_nettype none
// ============================================================================
// wide_add_sequencer : drives an external WIDTH-bit adder one slice per clock
//                      to build a WIDTH*WORDS-bit sum with rippled carry
// Revision: 1.0
// ============================================================================
module wide_add_sequencer #(
  parameter int WIDTH = 16,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  wide_add_sequencer_if.master   bus
);

  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          carry_q, carry_d;
  logic                          cout_q, cout_d;
  // Slice-indexed views keep the per-cycle select a plain array index.
  logic [WORDS-1:0][WIDTH-1:0]   a_q, a_d;
  logic [WORDS-1:0][WIDTH-1:0]   b_q, b_d;
  logic [WORDS-1:0][WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]              slice_a, slice_b;
  logic                          slice_cin;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    slice_a   = '0;
    slice_b   = '0;
    slice_cin = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d      = bus.op_a;
          b_d      = bus.op_b;
          carry_d  = bus.cin;
          cnt_d    = '0;
          result_d = '0;
          cout_d   = 1'b0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        slice_a           = a_q[cnt_q];
        slice_b           = b_q[cnt_q];
        slice_cin         = carry_q;
        result_d[cnt_q]   = bus.add_sum;
        carry_d           = bus.add_Cout;
        if (cnt_q == LAST_CNT) begin
          cout_d  = bus.add_Cout;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  assign bus.add_A   = slice_a;
  assign bus.add_B   = slice_b;
  assign bus.add_Cin = slice_cin;
  assign bus.result  = result_q;
  assign bus.cout    = cout_q;
  assign bus.busy    = (state_q == S_RUN);
  assign bus.done    = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_wide_add_sequencer.sv
`default_nettype none
// ============================================================================
// tb_wide_add_sequencer : table + random checks of a 4-slice and a 1-slice build
// Revision: 1.0
// ============================================================================
module tb_wide_add_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  wide_add_sequencer_if #(.WIDTH(16), .WORDS(4)) bus4 ();
  wide_add_sequencer_if #(.WIDTH(16), .WORDS(1)) bus1 ();

  wide_add_sequencer #(.WIDTH(16), .WORDS(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  wide_add_sequencer #(.WIDTH(16), .WORDS(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Behavioural stand-in for the external full_adder_16bit
  assign {bus4.add_Cout, bus4.add_sum} = {1'b0, bus4.add_A} + {1'b0, bus4.add_B} + 17'(bus4.add_Cin);
  assign {bus1.add_Cout, bus1.add_sum} = {1'b0, bus1.add_A} + {1'b0, bus1.add_B} + 17'(bus1.add_Cin);

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        c;
    logic [63:0] exp_r;
    logic        exp_c;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One full operation on the 4-slice build; expected values come from whole-word arithmetic.
  task automatic run4(input logic [63:0] a, input logic [63:0] b, input logic c,
                      input logic [63:0] exp_r, input logic exp_c,
                      input bit poke, input string tag);
    logic [64:0] part;
    logic [64:0] mask;
    int lat;
    int busy_n;
    @(negedge clk);
    bus4.start = 1'b1;
    bus4.op_a  = a;
    bus4.op_b  = b;
    bus4.cin   = c;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    bus4.op_a  = {$urandom, $urandom};
    bus4.op_b  = {$urandom, $urandom};
    bus4.cin   = 1'($urandom_range(0, 1));
    lat    = 0;
    busy_n = 0;
    while (bus4.done !== 1'b1 && lat < 20) begin
      if (bus4.busy === 1'b1) begin
        if (busy_n < 4) begin
          mask = (65'd1 << (16 * busy_n)) - 65'd1;
          part = ({1'b0, a} & mask) + ({1'b0, b} & mask) + 65'(c);
          chk({tag, " add_A"}, 64'(bus4.add_A), 64'(a[16*busy_n +: 16]));
          chk({tag, " add_B"}, 64'(bus4.add_B), 64'(b[16*busy_n +: 16]));
          chk({tag, " add_Cin"}, 64'(bus4.add_Cin), 64'(part[16*busy_n]));
        end
        busy_n++;
      end
      if (poke && lat == 1) begin
        bus4.start = 1'b1;
        bus4.op_a  = ~a;
        bus4.op_b  = {$urandom, $urandom};
        bus4.cin   = ~c;
      end else if (poke && lat == 2) begin
        bus4.start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    bus4.start = 1'b0;
    chk({tag, " latency"}, 64'(lat), 64'd4);
    chk({tag, " busy cycles"}, 64'(busy_n), 64'd4);
    chk({tag, " result"}, bus4.result, exp_r);
    chk({tag, " cout"}, 64'(bus4.cout), 64'(exp_c));
    chk({tag, " busy in done"}, 64'(bus4.busy), 64'd0);
    chk({tag, " add_A in done"}, 64'(bus4.add_A), 64'd0);
    @(posedge clk); #1;
    chk({tag, " done pulse width"}, 64'(bus4.done), 64'd0);
    chk({tag, " result held"}, bus4.result, exp_r);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[7];
    logic [63:0] ra, rb;
    logic        rc;
    logic [64:0] total;
    int          done_seen;
    int          lat1;

    vecs[0] = '{64'h0, 64'h0, 1'b0, 64'h0, 1'b0};
    vecs[1] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1};
    vecs[3] = '{64'hCCCC_CCCC_CCCC_CCCC, 64'h3333_3333_3333_3333, 1'b1, 64'h0, 1'b1};
    vecs[4] = '{64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[5] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1};
    vecs[6] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};

    rst = 1'b1;
    bus4.start = 1'b0; bus4.op_a = '0; bus4.op_b = '0; bus4.cin = 1'b0;
    bus1.start = 1'b0; bus1.op_a = '0; bus1.op_b = '0; bus1.cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset result", bus4.result, 64'h0);
    chk("reset cout", 64'(bus4.cout), 64'd0);
    chk("reset busy", 64'(bus4.busy), 64'd0);
    chk("reset done", 64'(bus4.done), 64'd0);
    chk("reset add_A", 64'(bus4.add_A), 64'd0);
    chk("reset add_Cin", 64'(bus4.add_Cin), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table vectors; entry 4 also pulses start mid-run to confirm it is ignored
    for (int i = 0; i < 7; i++) begin
      run4(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].exp_r, vecs[i].exp_c,
           (i == 4), $sformatf("vec%0d", i));
    end

    // Randomized operations against whole-word arithmetic
    for (int i = 0; i < 20; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      if (i % 5 == 0) rb = ~ra;
      total = {1'b0, ra} + {1'b0, rb} + 65'(rc);
      run4(ra, rb, rc, total[63:0], total[64], (i % 3 == 1), $sformatf("rnd%0d", i));
    end

    // Async reset during slice 2 discards the partial result
    @(negedge clk);
    bus4.start = 1'b1;
    bus4.op_a  = 64'h1111_1111_1111_1111;
    bus4.op_b  = 64'h2222_2222_2222_2222;
    bus4.cin   = 1'b0;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    chk("pre-reset partial result", bus4.result, 64'h0000_0000_3333_3333);
    rst = 1'b1;
    #1;
    chk("async rst result", bus4.result, 64'h0);
    chk("async rst cout", 64'(bus4.cout), 64'd0);
    chk("async rst busy", 64'(bus4.busy), 64'd0);
    chk("async rst done", 64'(bus4.done), 64'd0);
    chk("async rst add_A", 64'(bus4.add_A), 64'd0);
    chk("async rst add_B", 64'(bus4.add_B), 64'd0);
    chk("async rst add_Cin", 64'(bus4.add_Cin), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (bus4.done === 1'b1 || bus4.busy === 1'b1) done_seen++;
    end
    chk("no activity after reset", 64'(done_seen), 64'd0);
    run4(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0, "post-reset");

    // Single-slice build
    @(negedge clk);
    bus1.start = 1'b1;
    bus1.op_a  = 16'hFFFF;
    bus1.op_b  = 16'h0001;
    bus1.cin   = 1'b0;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    chk("w1 busy", 64'(bus1.busy), 64'd1);
    chk("w1 add_A", 64'(bus1.add_A), 64'hFFFF);
    lat1 = 0;
    while (bus1.done !== 1'b1 && lat1 < 10) begin
      @(posedge clk); #1;
      lat1++;
    end
    chk("w1 latency", 64'(lat1), 64'd1);
    chk("w1 result", 64'(bus1.result), 64'h0);
    chk("w1 cout", 64'(bus1.cout), 64'd1);
    @(posedge clk); #1;
    chk("w1 done pulse width", 64'(bus1.done), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
